// File: rtl/mc_control_fsm.sv
// Main control unit of the multi-cycle MIPS-subset core: a Moore sequencer that walks
// the shared datapath through fetch/decode/execute/memory/writeback steps.
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  state_t state_reg;

  // Memory states hold while mem_ready is low; op is only looked at in DECODE and MEMADR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      case (state_reg)
        FETCH:  if (mem_ready) state_reg <= DECODE;
        DECODE: begin
          if (op == OP_LW || op == OP_SW) state_reg <= MEMADR;
          else if (op == OP_RTYPE)        state_reg <= EXEC;
          else if (op == OP_BEQ)          state_reg <= BRANCH;
          else if (op == OP_J)            state_reg <= JUMP;
          else if (op == OP_ADDI)         state_reg <= ADDIEX;
          else                            state_reg <= FETCH;
        end
        MEMADR: state_reg <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready) state_reg <= MEMWB;
        MEMWB:  state_reg <= FETCH;
        MEMWR:  if (mem_ready) state_reg <= FETCH;
        EXEC:   state_reg <= RWB;
        RWB:    state_reg <= FETCH;
        BRANCH: state_reg <= FETCH;
        JUMP:   state_reg <= FETCH;
        ADDIEX: state_reg <= ADDIWB;
        ADDIWB: state_reg <= FETCH;
        default: state_reg <= FETCH;
      endcase
    end
  end

  // Decoded straight from the state register so reset forces the FETCH decode at once.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = 2'b01;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign state = state_reg;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: each instruction is played against a
// step-list model of the instruction flow and a per-step control-word table.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = OP_BAD;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst;
  logic [3:0] state;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .pc_source(pc_source), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  ctrl_t obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
                pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst};

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] tr_state[$];
  ctrl_t      tr_ctrl[$];
  logic       tr_mr[$];
  bit         tr_timeout;
  logic [3:0] exp_q[$];

  // Control word required in each named step of the instruction flow.
  function automatic ctrl_t exp_ctrl(input logic [3:0] s, input logic mr);
    ctrl_t c = '0;
    case (s)
      4'd0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      4'd1:  c.alu_src_b = 2'b11;
      4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.mem_read = 1; c.i_or_d = 1; end
      4'd4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      4'd5:  begin c.mem_write = 1; c.i_or_d = 1; end
      4'd6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_write = 1; c.reg_dst = 1; end
      4'd8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      4'd9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      4'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd11: c.reg_write = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Nominal instruction length with no memory stalls.
  function automatic int base_cycles(input logic [5:0] o);
    if (o == OP_LW) return 5;
    if (o == OP_SW || o == OP_RTYPE || o == OP_ADDI) return 4;
    if (o == OP_BEQ || o == OP_J) return 3;
    return 2;
  endfunction

  // Expected step list: fetch (with stalls), decode, then the opcode's own steps.
  task automatic build_expect(input logic [5:0] o, input int wf, input int wm);
    exp_q.delete();
    for (int i = 0; i < wf; i++) exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    if (o == OP_LW) begin
      exp_q.push_back(4'd2);
      for (int i = 0; i <= wm; i++) exp_q.push_back(4'd3);
      exp_q.push_back(4'd4);
    end else if (o == OP_SW) begin
      exp_q.push_back(4'd2);
      for (int i = 0; i <= wm; i++) exp_q.push_back(4'd5);
    end else if (o == OP_RTYPE) begin
      exp_q.push_back(4'd6); exp_q.push_back(4'd7);
    end else if (o == OP_BEQ) begin
      exp_q.push_back(4'd8);
    end else if (o == OP_J) begin
      exp_q.push_back(4'd9);
    end else if (o == OP_ADDI) begin
      exp_q.push_back(4'd10); exp_q.push_back(4'd11);
    end
  endtask

  // Plays one instruction from FETCH back to FETCH, recording a trace; op is scrambled
  // outside DECODE/MEMADR. Called just after a rising edge.
  task automatic run_instr(input logic [5:0] o, input int wf, input int wm);
    int  wf_left = wf;
    int  wm_left = wm;
    int  cyc = 0;
    bit  left_fetch = 0;
    tr_state.delete(); tr_ctrl.delete(); tr_mr.delete();
    tr_timeout = 0;
    while (!(state == 4'd0 && left_fetch)) begin
      if (cyc >= 40) begin
        tr_timeout = 1;
        break;
      end
      op = (state == 4'd1 || state == 4'd2) ? o : 6'($urandom);
      if (state == 4'd0) begin
        mem_ready = (wf_left == 0);
        if (wf_left > 0) wf_left--;
      end else if (state == 4'd3 || state == 4'd5) begin
        mem_ready = (wm_left == 0);
        if (wm_left > 0) wm_left--;
      end else begin
        mem_ready = 1'($urandom);
      end
      @(negedge clk);
      tr_state.push_back(state);
      tr_ctrl.push_back(obs);
      tr_mr.push_back(mem_ready);
      if (state != 4'd0) left_fetch = 1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    ctrl_t want;
    rst_n = 1'b0; mem_ready = 1'b0; op = OP_BAD;
    #12;
    want = '0; want.mem_read = 1; want.alu_src_b = 2'b01;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    n_checks++;
    if (obs !== want) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, want);
    end
    @(negedge clk);
    mem_ready = 1'b1; rst_n = 1'b1;
    #1;
    want.pc_write = 1; want.ir_write = 1;
    n_checks++;
    if (state !== 4'd0 || obs !== want) begin
      n_fail++; $display("FAIL release_fetch: got state %0d ctrl %h expected state 0 ctrl %h", state, obs, want);
    end
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd1) begin
      n_fail++; $display("FAIL release_decode: got %0d expected 1", state);
    end
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL release_nop_return: got %0d expected 0", state);
    end
  endtask

  task automatic test_directed();
    logic [5:0] ops[10] = '{OP_LW, OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, OP_BAD, OP_LW, OP_SW};
    int         wfs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
    int         wms[10] = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 2};
    int         want_len;
    for (int k = 0; k < 10; k++) begin
      run_instr(ops[k], wfs[k], wms[k]);
      build_expect(ops[k], wfs[k], wms[k]);
      want_len = base_cycles(ops[k]) + wfs[k] + ((ops[k] == OP_LW || ops[k] == OP_SW) ? wms[k] : 0);
      n_checks++;
      if (tr_timeout || tr_state.size() != want_len) begin
        n_fail++;
        $display("FAIL dir%0d_cycles op=%b: got %0d cycles (timeout=%0d) expected %0d",
                 k, ops[k], tr_state.size(), tr_timeout, want_len);
      end
      for (int i = 0; i < tr_state.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (tr_state[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL dir%0d_state[%0d] op=%b: got %0d expected %0d", k, i, ops[k], tr_state[i], exp_q[i]);
        end
        n_checks++;
        if (tr_ctrl[i] !== exp_ctrl(exp_q[i], tr_mr[i])) begin
          n_fail++; $display("FAIL dir%0d_ctrl[%0d] op=%b state=%0d: got %h expected %h",
                             k, i, ops[k], exp_q[i], tr_ctrl[i], exp_ctrl(exp_q[i], tr_mr[i]));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    ctrl_t want;
    op = OP_SW; mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      op = (state == 4'd1 || state == 4'd2) ? OP_SW : 6'($urandom);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      n_fail++; $display("FAIL memwr_wait: got state %0d mem_write %b expected 5 / 1", state, mem_write);
    end
    #2 rst_n = 1'b0;
    #1;
    want = '0; want.mem_read = 1; want.alu_src_b = 2'b01;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL async_reset_state: got %0d expected 0", state);
    end
    n_checks++;
    if (obs !== want) begin
      n_fail++; $display("FAIL async_reset_ctrl: got %h expected %h", obs, want);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL fetch_hold: got %0d expected 0", state);
    end
  endtask

  task automatic test_random_stream();
    logic [5:0] pool[6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    logic [5:0] o;
    int         wf, wm, sel;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 7);
      o = (sel < 6) ? pool[sel] : 6'($urandom);
      wf = $urandom_range(0, 2);
      wm = $urandom_range(0, 3);
      run_instr(o, wf, wm);
      build_expect(o, wf, wm);
      n_checks++;
      if (tr_timeout || tr_state.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rnd%0d_length op=%b: got %0d (timeout=%0d) expected %0d",
                           k, o, tr_state.size(), tr_timeout, exp_q.size());
      end
      for (int i = 0; i < tr_state.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (tr_state[i] !== exp_q[i] || tr_ctrl[i] !== exp_ctrl(exp_q[i], tr_mr[i])) begin
          n_fail++; $display("FAIL rnd%0d_step[%0d] op=%b: got state %0d ctrl %h expected state %0d ctrl %h",
                             k, i, o, tr_state[i], tr_ctrl[i], exp_q[i], exp_ctrl(exp_q[i], tr_mr[i]));
        end
        n_checks++;
        if ((tr_ctrl[i].pc_write & tr_ctrl[i].pc_write_cond) !== 1'b0 ||
            (tr_ctrl[i].mem_read & tr_ctrl[i].mem_write) !== 1'b0) begin
          n_fail++; $display("FAIL rnd%0d_exclusive[%0d]: got ctrl %h expected no strobe overlap", k, i, tr_ctrl[i]);
        end
      end
      $display("instr %0d op=%b fetch_wait=%0d mem_wait=%0d cycles=%0d", k, o, wf, wm, tr_state.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_async_reset();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Main control unit for the multi-cycle MIPS-subset processor. It is a Moore state machine that decodes the 6-bit opcode and sequences the shared datapath (PC, unified memory, IR, register file, ALU) through fetch, decode, execute, memory and writeback steps. Each step is one or more clock cycles. It drives every datapath mux select and write enable. PCWriteCond feeds the existing Branch/Zero AND gate, whose output is ORed with PCWrite to form the PC load enable.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch if equal
OP_J, 6'b000010, jump
OP_ADDI, 6'b001000, add immediate

Ports:
Clk  input  1  system clock, rising-edge
Rst_n  input  1  asynchronous active-low reset
Op  input  6  IR[31:26], valid from Decode onward
MemReady  input  1  memory access completes this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  conditional PC load (Branch), to the AND gate
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
MemtoReg  output  1  register write data: 0=ALUOut, 1=MDR
IRWrite  output  1  instruction register load
PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
ALUOp  output  2  00=add, 01=sub, 10=funct-decode
ALUSrcA  output  1  0=PC, 1=rs register A
ALUSrcB  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
RegWrite  output  1  register file write enable
RegDst  output  1  0=rt, 1=rd
State  output  4  current state, for debug and test

Behaviour:
- Interface: one clock, Clk. Reset Rst_n is asynchronous and active-low. While Rst_n=0, State=FETCH(0) immediately, independent of Clk.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are illegal and go to FETCH on the next edge. All outputs are 0 in illegal states.
- Outputs are a pure combinational decode of State (Moore). Any output not listed for a state is 0.
- FETCH: MemRead=1, IRWrite=MemReady, ALUSrcB=01, ALUOp=00, PCWrite=MemReady, PCSource=00. Holds in FETCH while MemReady=0. Goes to DECODE when MemReady=1.
- Reset values: outputs equal the FETCH decode. With MemReady=0 during reset, only MemRead=1 and ALUSrcB=01 are high, so PC and IR are not disturbed.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target computed into ALUOut). Next state by Op:
  - LW or SW → MEMADR
  - RTYPE → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDIEX
  - any other opcode → FETCH (instruction ignored as a NOP)
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if Op=LW, otherwise MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady=1, then goes to FETCH. MemWrite stays asserted for every wait cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- Instruction cycle counts with MemReady held at 1:
  - LW = 5
  - SW, R-type, ADDI = 4
  - BEQ, J = 3
  - Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- PCWrite and PCWriteCond are never both 1. MemRead and MemWrite are never both 1.
- Reset mid-instruction (including during a memory wait): State goes to FETCH asynchronously. No write strobe may remain high after Rst_n falls.
- Op is sampled only in DECODE and MEMADR. Op changing in any other state has no effect.

Test Plan:
- Reset: hold Rst_n=0 with MemReady=0 → State=0, MemRead=1, ALUSrcB=01, all other outputs 0. Release with MemReady=1 → FETCH→DECODE on the first edge, with PCWrite=1 and IRWrite=1 in the FETCH cycle.
- LW with MemReady=1 → State sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. Insert 2 cycles of MemReady=0 in MEMRD → state 3 held for 3 cycles with IorD=1.
- SW, then R-type, then ADDI → sequences 0,1,2,5,0; 0,1,6,7,0; 0,1,10,11,0. RegDst=1 only in state 7. MemWrite=1 only in state 5.
- BEQ → 0,1,8,0 with PCWriteCond=1, ALUOp=01, PCSource=01 in state 8. J → 0,1,9,0 with PCWrite=1, PCSource=10.
- Undefined opcode 6'b111111 → DECODE→FETCH with no RegWrite, MemWrite or PCWrite asserted outside FETCH.
- Assert Rst_n=0 mid-cycle during MEMWR with MemReady=0 → State=0 and MemWrite=0 before the next Clk edge. Across a random instruction stream, PCWrite&PCWriteCond and MemRead&MemWrite are never 1.
